ks_sum_out_16b: RTL and testbench

//  Final sum/output stage of the 16-bit Kogge-Stone adder pipeline (FFT datapath).

---
 rtl/ks_sum_out_16b_pkg.sv | 46 ++++
 rtl/ks_sum_out_16b_skid_reg.sv | 57 +++++
 rtl/ks_sum_out_16b.sv | 60 ++++++
 tb/tb_ks_sum_out_16b.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_sum_out_16b_pkg.sv
// Shared definitions for the Kogge-Stone final sum stage: widths,
// saturation limits, the packed result layout and the sum/flag helper.
package ks_sum_out_16b_pkg;

   localparam int KS_W = 16;
   localparam logic [KS_W-1:0] KS_SAT_POS = 16'h7FFF;
   localparam logic [KS_W-1:0] KS_SAT_NEG = 16'h8000;

   // Everything that travels with one result word except the sideband tag
   typedef struct packed {
      logic [KS_W-1:0] sum;
      logic            cout;
      logic            ovf;
      logic            zero;
      logic            propAll;
   } ks_result_t;

   localparam int KS_RESULT_W = $bits(ks_result_t);

   // Turns saved propagates and carries into sum and flags. The carry into
   // bit k is the group generate of bit k-1, with c0 feeding bit 0.
   function automatic ks_result_t ksFormResult(
      input logic [KS_W-1:0] pk,
      input logic [KS_W-1:0] gk,
      input logic            c0,
      input logic            pAll,
      input logic            sat
   );
      ks_result_t      res;
      logic [KS_W-1:0] rawSum;
      logic            ovf;
      rawSum = pk ^ {gk[KS_W-2:0], c0};
      ovf    = gk[KS_W-1] ^ gk[KS_W-2];
      if (sat && ovf) begin
         res.sum = rawSum[KS_W-1] ? KS_SAT_POS : KS_SAT_NEG;
      end else begin
         res.sum = rawSum;
      end
      res.cout    = gk[KS_W-1];
      res.ovf     = ovf;
      res.zero    = (res.sum == '0);
      res.propAll = pAll;
      return res;
   endfunction

endpackage

// File: rtl/ks_sum_out_16b_skid_reg.sv
// Generic two-entry valid/ready skid register. M drives the outputs; S
// catches the one word that arrives while M is stalled, and a full S
// deasserts ready from a flop so no combinational path crosses the stage.
module ks_sum_out_16b_skid_reg #(
   parameter int DW = 8
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [DW-1:0] o_data
);

   logic          r_mValid;
   logic [DW-1:0] r_mData;
   logic          r_sValid;
   logic [DW-1:0] r_sData;
   logic          r_ready;
   logic          w_accept;
   logic          w_emit;

   assign w_accept = i_valid & r_ready;
   assign w_emit   = r_mValid & i_ready;

   // Move words between input, skid and main entries; S is only ever filled
   // while M is stalled, and drains into M before new input is taken again.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mValid <= 1'b0;
         r_mData  <= '0;
         r_sValid <= 1'b0;
         r_sData  <= '0;
         r_ready  <= 1'b1;
      end else if (w_emit && r_sValid) begin
         r_mData  <= r_sData;
         r_sValid <= 1'b0;
         r_ready  <= 1'b1;
      end else if (w_accept && (!r_mValid || w_emit)) begin
         r_mValid <= 1'b1;
         r_mData  <= i_data;
      end else if (w_accept) begin
         r_sValid <= 1'b1;
         r_sData  <= i_data;
         r_ready  <= 1'b0;
      end else if (w_emit) begin
         r_mValid <= 1'b0;
      end
   end

   assign o_ready = r_ready;
   assign o_valid = r_mValid;
   assign o_data  = r_mData;

endmodule

// File: rtl/ks_sum_out_16b.sv
// Final sum/output stage of the 16-bit Kogge-Stone adder: forms sum, carry,
// overflow and zero flags (optionally saturating) and registers them with the
// tag behind a skid buffer so the adder tree can stall cleanly.
module ks_sum_out_16b
   import ks_sum_out_16b_pkg::*;
#(
   parameter int SATURATE = 0,
   parameter int TAG_W    = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_c0,
   input  logic [KS_W-1:0]  i_pk,
   input  logic [KS_W-1:0]  i_gk,
   input  logic             i_p_addn,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [KS_W-1:0]  o_sum,
   output logic             o_cout,
   output logic             o_ovf,
   output logic             o_zero,
   output logic             o_prop_all,
   output logic [TAG_W-1:0] o_tag
);

   localparam int DW = KS_RESULT_W + TAG_W;

   ks_result_t       w_result;
   ks_result_t       w_outResult;
   logic [DW-1:0]    w_inWord;
   logic [DW-1:0]    w_outWord;

   assign w_result = ksFormResult(i_pk, i_gk, i_c0, i_p_addn, (SATURATE != 0));
   assign w_inWord = {w_result, i_tag};

   ks_sum_out_16b_skid_reg #(
      .DW(DW)
   ) u_skid (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  (w_inWord),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (w_outWord)
   );

   assign w_outResult = w_outWord[DW-1:TAG_W];
   assign o_tag       = w_outWord[TAG_W-1:0];
   assign o_sum       = w_outResult.sum;
   assign o_cout      = w_outResult.cout;
   assign o_ovf       = w_outResult.ovf;
   assign o_zero      = w_outResult.zero;
   assign o_prop_all  = w_outResult.propAll;

endmodule

// File: tb/tb_ks_sum_out_16b.sv
// Bench for the Kogge-Stone sum stage: a wrapping and a saturating instance
// share the same stimulus; directed vectors, stall/reset sequences and a
// random handshake run against an a+b+c0 scoreboard.
module tb_ks_sum_out_16b;

   localparam int N_RAND    = 2000;
   localparam int CYC_LIMIT = 20000;

   typedef struct {
      logic [15:0] pk;
      logic [15:0] gk;
      logic        c0;
      logic        pAll;
      logic [3:0]  tag;
      logic [15:0] sum0;
      logic [15:0] sum1;
      logic        cout;
      logic        ovf;
      logic        zero0;
      logic        zero1;
   } vec_t;

   typedef struct {
      logic [15:0] sum0;
      logic [15:0] sum1;
      logic        cout;
      logic        ovf;
      logic        zero0;
      logic        zero1;
      logic        pAll;
      logic [3:0]  tag;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        i_valid;
   logic        i_c0;
   logic [15:0] i_pk;
   logic [15:0] i_gk;
   logic        i_p_addn;
   logic [3:0]  i_tag;
   logic        i_ready;

   logic        o_ready0, o_valid0, o_cout0, o_ovf0, o_zero0, o_prop0;
   logic [15:0] o_sum0;
   logic [3:0]  o_tag0;
   logic        o_ready1, o_valid1, o_cout1, o_ovf1, o_zero1, o_prop1;
   logic [15:0] o_sum1;
   logic [3:0]  o_tag1;

   int   checks;
   int   errors;
   vec_t vecs[7];
   exp_t q[$];
   exp_t curExp;
   exp_t front;

   ks_sum_out_16b #(.SATURATE(0), .TAG_W(4)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready0),
      .i_c0(i_c0), .i_pk(i_pk), .i_gk(i_gk), .i_p_addn(i_p_addn), .i_tag(i_tag),
      .o_valid(o_valid0), .i_ready(i_ready), .o_sum(o_sum0), .o_cout(o_cout0),
      .o_ovf(o_ovf0), .o_zero(o_zero0), .o_prop_all(o_prop0), .o_tag(o_tag0)
   );

   ks_sum_out_16b #(.SATURATE(1), .TAG_W(4)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready1),
      .i_c0(i_c0), .i_pk(i_pk), .i_gk(i_gk), .i_p_addn(i_p_addn), .i_tag(i_tag),
      .o_valid(o_valid1), .i_ready(i_ready), .o_sum(o_sum1), .o_cout(o_cout1),
      .o_ovf(o_ovf1), .o_zero(o_zero1), .o_prop_all(o_prop1), .o_tag(o_tag1)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and reports it when actual and expected differ
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends one table vector with downstream always ready and checks it a cycle later
   task automatic applyStimulus(input vec_t v, input int idx);
      string tagName;
      i_pk     = v.pk;
      i_gk     = v.gk;
      i_c0     = v.c0;
      i_p_addn = v.pAll;
      i_tag    = v.tag;
      i_valid  = 1'b1;
      tick();
      i_valid  = 1'b0;
      @(negedge clk);
      tagName = $sformatf("vec%0d", idx);
      checkOutput({tagName, "_valid"}, 32'(o_valid0), 32'd1);
      checkOutput({tagName, "_sum0"},  32'(o_sum0),   32'(v.sum0));
      checkOutput({tagName, "_cout0"}, 32'(o_cout0),  32'(v.cout));
      checkOutput({tagName, "_ovf0"},  32'(o_ovf0),   32'(v.ovf));
      checkOutput({tagName, "_zero0"}, 32'(o_zero0),  32'(v.zero0));
      checkOutput({tagName, "_prop0"}, 32'(o_prop0),  32'(v.pAll));
      checkOutput({tagName, "_tag0"},  32'(o_tag0),   32'(v.tag));
      checkOutput({tagName, "_sum1"},  32'(o_sum1),   32'(v.sum1));
      checkOutput({tagName, "_zero1"}, 32'(o_zero1),  32'(v.zero1));
      checkOutput({tagName, "_ovf1"},  32'(o_ovf1),   32'(v.ovf));
   endtask

   // Builds adder inputs from operands and the expected results from plain addition
   task automatic genWord(input logic [15:0] a, input logic [15:0] b,
                          input logic c0, input logic [3:0] tag);
      logic        c;
      logic [16:0] full;
      logic [15:0] raw;
      c = c0;
      for (int k = 0; k < 16; k++) begin
         c = (a[k] & b[k]) | ((a[k] ^ b[k]) & c);
         i_gk[k] = c;
      end
      i_pk     = a ^ b;
      i_c0     = c0;
      i_p_addn = &(a ^ b);
      i_tag    = tag;
      full     = {1'b0, a} + {1'b0, b} + {16'd0, c0};
      raw      = full[15:0];
      curExp.cout  = full[16];
      curExp.ovf   = (a[15] == b[15]) && (raw[15] != a[15]);
      curExp.sum0  = raw;
      curExp.sum1  = curExp.ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : raw;
      curExp.zero0 = (curExp.sum0 == 16'h0);
      curExp.zero1 = (curExp.sum1 == 16'h0);
      curExp.pAll  = &(a ^ b);
      curExp.tag   = tag;
   endtask

   initial begin
      int          cyc;
      int          sent;
      int          got;
      logic        acc;
      logic        em;
      logic [15:0] a;
      logic [15:0] b;

      checks = 0;
      errors = 0;

      //                pk        gk        c0    pAll  tag   sum0      sum1      cout  ovf   z0    z1
      vecs[0] = '{16'h00FE, 16'h00FF, 1'b0, 1'b0, 4'd1, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'h7FFE, 16'h8000, 1'b1, 1'b0, 4'd2, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 4'd3, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{16'h0000, 16'h8000, 1'b0, 1'b0, 4'd4, 16'h0000, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{16'h7FFE, 16'h7FFF, 1'b0, 1'b0, 4'd5, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{16'h5115, 16'h0220, 1'b0, 1'b0, 4'd6, 16'h5555, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 4'd7, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};

      rst_n    = 1'b0;
      i_valid  = 1'b0;
      i_ready  = 1'b0;
      i_c0     = 1'b0;
      i_pk     = 16'h0;
      i_gk     = 16'h0;
      i_p_addn = 1'b0;
      i_tag    = 4'h0;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_valid", 32'(o_valid0), 32'd0);
      checkOutput("rst_fields", 32'({o_sum0, o_cout0, o_ovf0, o_zero0, o_prop0, o_tag0}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_ready", 32'(o_ready0), 32'd1);

      // Table vectors with downstream always ready
      i_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i], i);
      end
      tick();
      @(negedge clk);
      checkOutput("drain_valid", 32'(o_valid0), 32'd0);

      // Back-to-back tags 1,2,3 while downstream stalls for two cycles
      i_ready  = 1'b0;
      i_pk     = vecs[0].pk;
      i_gk     = vecs[0].gk;
      i_c0     = vecs[0].c0;
      i_p_addn = vecs[0].pAll;
      i_tag    = 4'd1;
      i_valid  = 1'b1;
      tick();
      i_tag = 4'd2;
      tick();
      i_tag = 4'd3;
      @(negedge clk);
      checkOutput("stall_ready_low", 32'(o_ready0), 32'd0);
      checkOutput("stall_tag1", 32'(o_tag0), 32'd1);
      checkOutput("stall_valid", 32'(o_valid0), 32'd1);
      tick();
      @(negedge clk);
      checkOutput("stall_tag1_hold", 32'(o_tag0), 32'd1);
      checkOutput("stall_sum_hold", 32'(o_sum0), 32'h0100);
      i_ready = 1'b1;
      tick();
      @(negedge clk);
      checkOutput("stall_tag2", 32'(o_tag0), 32'd2);
      checkOutput("stall_ready_up", 32'(o_ready0), 32'd1);
      tick();
      i_valid = 1'b0;
      @(negedge clk);
      checkOutput("stall_tag3", 32'(o_tag0), 32'd3);
      checkOutput("stall_valid3", 32'(o_valid0), 32'd1);
      tick();
      @(negedge clk);
      checkOutput("stall_empty", 32'(o_valid0), 32'd0);

      // Asynchronous reset while two words are buffered
      i_ready = 1'b0;
      i_tag   = 4'd5;
      i_valid = 1'b1;
      tick();
      i_tag = 4'd6;
      tick();
      i_valid = 1'b0;
      @(negedge clk);
      checkOutput("mid_ready_low", 32'(o_ready0), 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_valid", 32'(o_valid0), 32'd0);
      checkOutput("mid_rst_fields", 32'({o_sum0, o_cout0, o_ovf0, o_zero0, o_prop0, o_tag0}), 32'd0);
      checkOutput("mid_rst_sat_fields", 32'({o_valid1, o_sum1, o_tag1}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      checkOutput("mid_rel_ready", 32'(o_ready0), 32'd1);
      checkOutput("mid_rel_ready1", 32'(o_ready1), 32'd1);
      checkOutput("mid_rel_valid", 32'(o_valid0), 32'd0);

      // Random handshake against the scoreboard
      cyc  = 0;
      sent = 0;
      got  = 0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      while ((sent < N_RAND || q.size() != 0) && cyc < CYC_LIMIT) begin
         @(negedge clk);
         cyc++;
         acc = i_valid && o_ready0;
         em  = o_valid0 && i_ready;
         if (em) begin
            checkOutput("rnd_queue_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               front = q.pop_front();
               got++;
               checkOutput("rnd_word0",
                  32'({o_sum0, o_cout0, o_ovf0, o_zero0, o_prop0, o_tag0}),
                  32'({front.sum0, front.cout, front.ovf, front.zero0, front.pAll, front.tag}));
               checkOutput("rnd_word1",
                  32'({o_valid1, o_sum1, o_cout1, o_ovf1, o_zero1, o_prop1, o_tag1}),
                  32'({1'b1, front.sum1, front.cout, front.ovf, front.zero1, front.pAll, front.tag}));
            end
         end
         if (acc) begin
            q.push_back(curExp);
            sent++;
         end
         tick();
         if (acc || !i_valid) begin
            if (sent < N_RAND && $urandom_range(0, 3) != 0) begin
               a = 16'($urandom);
               b = ($urandom_range(0, 7) == 0) ? ~a : 16'($urandom);
               genWord(a, b, 1'($urandom_range(0, 1)), 4'($urandom));
               i_valid = 1'b1;
            end else begin
               i_valid = 1'b0;
            end
         end
         i_ready = ($urandom_range(0, 3) != 0);
      end
      checkOutput("rnd_no_timeout", 32'(cyc < CYC_LIMIT), 32'd1);
      checkOutput("rnd_count", 32'(got), 32'(N_RAND));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
